// File: rtl/reg_file_mp.sv
// Multi-read-port register file with per-register pending bits.
// One write port, NUM_RD registered read ports with same-cycle write forwarding.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rdEn,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdValid,
    output logic [NUM_RD-1:0]        rdBusy,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     setBusy,
    input  logic [ADDR_W-1:0]        setAddr,
    output logic                     anyBusy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         pend;
    logic [DEPTH-1:0]         pend_nxt;
    logic                     wr_ok;
    logic                     set_ok;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;

    assign wr_ok  = wrEn && !((ZERO_REG != 0) && (wrAddr == '0));
    assign set_ok = setBusy && !((ZERO_REG != 0) && (setAddr == '0));

    // Pending update: a write clears, a set marks; set wins on collision
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) begin
            pend_nxt[wrAddr] = 1'b0;
        end
        if (set_ok) begin
            pend_nxt[setAddr] = 1'b1;
        end
    end

    // Read lookup per port: zero register, then write forwarding, then array
    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ((ZERO_REG != 0) && (rdAddr[i*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_nxt[i*DATA_W +: DATA_W] = '0;
                rd_busy_nxt[i]                  = 1'b0;
            end else if (wr_ok && (wrAddr == rdAddr[i*ADDR_W +: ADDR_W])) begin
                rd_data_nxt[i*DATA_W +: DATA_W] = wrData;
                rd_busy_nxt[i]                  = 1'b0;
            end else begin
                rd_data_nxt[i*DATA_W +: DATA_W] = regs[rdAddr[i*ADDR_W +: ADDR_W]];
                rd_busy_nxt[i]                  = pend[rdAddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Register array storage; register 0 is never written when hardwired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Pending-bit storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Registered read outputs; data and busy hold when a port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData  <= '0;
            rdBusy  <= '0;
            rdValid <= '0;
        end else begin
            rdValid <= rdEn;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rdEn[i]) begin
                    rdData[i*DATA_W +: DATA_W] <= rd_data_nxt[i*DATA_W +: DATA_W];
                    rdBusy[i]                  <= rd_busy_nxt[i];
                end
            end
        end
    end

    assign anyBusy = |pend;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp with default parameters.
// Stimulus pushes expected results; a monitor pops them as outputs appear.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rdEn = '0;
    logic [9:0]  rdAddr = '0;
    logic [63:0] rdData;
    logic [1:0]  rdValid;
    logic [1:0]  rdBusy;
    logic        wrEn = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic        setBusy = 1'b0;
    logic [4:0]  setAddr = '0;
    logic        anyBusy;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: register contents and pending flags
    logic [31:0] mem [32];
    bit          pnd [32];

    // Expected {busy, data} per port, and expected anyBusy per cycle
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    bit          aq [$];
    logic [32:0] last0 = '0;
    logic [32:0] last1 = '0;

    reg_file_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdEn    (rdEn),
        .rdAddr  (rdAddr),
        .rdData  (rdData),
        .rdValid (rdValid),
        .rdBusy  (rdBusy),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .setBusy (setBusy),
        .setAddr (setAddr),
        .anyBusy (anyBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Value a read of address a returns, given this cycle's write
    function automatic logic [32:0] model_rd(input logic [4:0] a,
                                             input logic we,
                                             input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (a == 5'd0) return 33'd0;
        if (we && wa == a) return {1'b0, wd};
        return {pnd[a], mem[a]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            mem[k] = '0;
            pnd[k] = 1'b0;
        end
    endtask

    task automatic cycle(input logic [1:0] re, input logic [4:0] a0,
                         input logic [4:0] a1, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic se, input logic [4:0] sa);
        int n;
        @(negedge clk);
        rdEn    = re;
        rdAddr  = {a1, a0};
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        setBusy = se;
        setAddr = sa;
        if (re[0]) q0.push_back(model_rd(a0, we, wa, wd));
        if (re[1]) q1.push_back(model_rd(a1, we, wa, wd));
        if (we && wa != 5'd0) begin
            mem[wa] = wd;
            pnd[wa] = 1'b0;
        end
        if (se && sa != 5'd0) pnd[sa] = 1'b1;
        n = 0;
        for (int k = 0; k < 32; k++) n += int'(pnd[k]);
        aq.push_back(n != 0);
    endtask

    task automatic idle_inputs();
        rdEn    = '0;
        wrEn    = 1'b0;
        setBusy = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdValid[0]) begin
                if (q0.size() == 0) begin
                    chk("port0_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    last0 = q0.pop_front();
                    chk("port0_read", {rdBusy[0], rdData[31:0]}, last0);
                end
            end else begin
                chk("port0_hold", {rdBusy[0], rdData[31:0]}, last0);
            end
            if (rdValid[1]) begin
                if (q1.size() == 0) begin
                    chk("port1_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    last1 = q1.pop_front();
                    chk("port1_read", {rdBusy[1], rdData[63:32]}, last1);
                end
            end else begin
                chk("port1_hold", {rdBusy[1], rdData[63:32]}, last1);
            end
            if (aq.size() > 0) chk("anyBusy", anyBusy, aq.pop_front());
        end
    end

    initial begin
        model_clear();
        #12;
        chk("reset_rdValid", rdValid, 0);
        chk("reset_rdData", rdData, 0);
        chk("reset_rdBusy", rdBusy, 0);
        chk("reset_anyBusy", anyBusy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reads right after reset return zero
        cycle(2'b11, 5'd3, 5'd5, 0, 0, 0, 0, 0);
        // Write then read, and same-cycle forwarding
        cycle(2'b00, 0, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0);
        cycle(2'b11, 5'd7, 5'd9, 1, 5'd9, 32'h12345678, 0, 0);
        cycle(2'b10, 0, 5'd9, 0, 0, 0, 0, 0);
        // Register 0 is hardwired, including the forwarding path
        cycle(2'b00, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
        cycle(2'b11, 5'd0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0);
        cycle(2'b11, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        // Pending bit set, observed, cleared by write, set/write collision
        cycle(2'b00, 0, 0, 0, 0, 0, 1, 5'd4);
        cycle(2'b11, 5'd4, 5'd4, 0, 0, 0, 0, 0);
        cycle(2'b00, 0, 0, 1, 5'd4, 32'h55, 0, 0);
        cycle(2'b01, 5'd4, 0, 0, 0, 0, 0, 0);
        cycle(2'b00, 0, 0, 1, 5'd4, 32'h66, 1, 5'd4);
        cycle(2'b11, 5'd4, 5'd4, 0, 0, 0, 0, 0);
        // Set and read same address: busy reflects pre-edge state
        cycle(2'b01, 5'd6, 0, 0, 0, 0, 1, 5'd6);
        cycle(2'b01, 5'd6, 0, 0, 0, 0, 0, 0);

        // Reset asserted between read request and response
        cycle(2'b00, 0, 0, 0, 0, 0, 1, 5'd2);
        @(negedge clk);
        rdEn   = 2'b11;
        rdAddr = {5'd2, 5'd2};
        wrEn   = 1'b0;
        setBusy = 1'b0;
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        aq.delete();
        model_clear();
        last0 = '0;
        last1 = '0;
        #1;
        chk("midreset_anyBusy", anyBusy, 0);
        chk("midreset_rdValid", rdValid, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        cycle(2'b11, 5'd2, 5'd2, 0, 0, 0, 0, 0);

        // Randomized traffic, mostly in a small address window
        repeat (400) begin
            logic [4:0] a0, a1, wa, sa;
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            a0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            sa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            cycle(2'($urandom), a0, a1, 1'($urandom), wa, $urandom,
                  ($urandom_range(0, 3) == 0), sa);
        end

        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size() + aq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Parameters
REQ-001 SHALL provide DATA_W, default 32, data width of every register.
REQ-002 SHALL provide ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide ZERO_REG, default 1, 1 = register 0 hardwired to zero and unwritable.

Interface
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have rdEn  input  NUM_RD  per-port read request.
REQ-008 SHALL have rdAddr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have rdData  output  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have rdValid  output  NUM_RD  rdData[i] updated by a read in the previous cycle.
REQ-011 SHALL have rdBusy  output  NUM_RD  source register of port i was pending at read time.
REQ-012 SHALL have wrEn  input  1  write request.
REQ-013 SHALL have wrAddr  input  ADDR_W  write address.
REQ-014 SHALL have wrData  input  DATA_W  write data.
REQ-015 SHALL have setBusy  input  1  mark setAddr as pending (result in flight).
REQ-016 SHALL have setAddr  input  ADDR_W  register to mark pending.
REQ-017 SHALL have anyBusy  output  1  OR of all pending bits.

Function
REQ-018 SHALL store 2**ADDR_W registers of DATA_W bits plus one pending bit per register.
REQ-019 SHALL, on a rising edge with wrEn=1, write wrData to wrAddr and clear its pending bit; writes to address 0 SHALL be ignored when ZERO_REG=1.
REQ-020 SHALL, on a rising edge with rdEn[i]=1, load rdData[i], rdBusy[i] and set rdValid[i]=1; latency is one cycle.
REQ-021 SHALL hold rdData[i] and rdBusy[i] and drive rdValid[i]=0 on any edge with rdEn[i]=0.
REQ-022 SHALL forward: if wrEn=1 and wrAddr==rdAddr[i] in the same cycle (and the address is writable), rdData[i] SHALL capture wrData and rdBusy[i] SHALL capture 0.
REQ-023 SHALL return 0 with rdBusy=0 for reads of address 0 when ZERO_REG=1, including the same-cycle write case.
REQ-024 SHALL, on setBusy=1, set the pending bit of setAddr; setBusy to address 0 ignored when ZERO_REG=1.
REQ-025 SHALL give setBusy priority over the wrEn clear when setAddr==wrAddr in the same cycle (data still written, bit ends set).
REQ-026 SHALL, when setBusy and rdEn[i] target the same address in the same cycle, report rdBusy[i] from the pre-edge pending state (with REQ-022 forwarding applied).
REQ-027 SHALL allow all read ports to access the same address simultaneously with identical results.
REQ-028 SHALL drive anyBusy combinationally from the current pending bits.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear all registers, all pending bits, rdData, rdValid and rdBusy to 0; anyBusy therefore 0.
REQ-030 SHALL ignore rdEn, wrEn and setBusy while rst_n=0; first update occurs on the first rising edge after rst_n deasserts.
REQ-031 SHALL discard an in-flight read (rdValid stays 0) when reset asserts between request and response.

Verification
REQ-032 Reset, then rdEn=2'b11, rdAddr={5,3} -> next cycle rdData={0,0}, rdValid=2'b11, rdBusy=2'b00.
REQ-033 Write 0xDEADBEEF to r7; next cycle read r7 on port 0 -> rdData[0]=0xDEADBEEF; same-cycle write 0x12345678 to r9 with read r9 on port 1 -> rdData[1]=0x12345678.
REQ-034 Write 0xFFFFFFFF to r0 (ZERO_REG=1), then read r0 on both ports -> both 0, rdBusy=0.
REQ-035 setBusy r4 -> anyBusy=1, read r4 -> rdBusy=1; write r4=0x55 -> anyBusy=0, next read r4 -> 0x55, rdBusy=0; setBusy and wrEn both r4 same cycle -> bit remains set.
REQ-036 setBusy r2, pulse rst_n=0 mid-read -> rdValid=0, anyBusy=0, read r2 -> 0, rdBusy=0.
